kernel_coef_bank: RTL
=====================

Name: kernel_coef_bank

Overview:
- Parametrised, multi-kernel coefficient store for the D8M video filter path. It is the successor to the single fixed 5x5 Gaussian row ROM.
- Holds NKERN kernels of KSIZE x KSIZE unsigned coefficients. On a start request it streams one kernel row per beat to the convolution datapath over a valid/ready handshake.
- Kernel select is latched per frame/operation. An optional write port lets software reload coefficients at runtime.

Parameters:
- KSIZE, 5: kernel dimension. Gives rows per kernel and coefficients per row. Legal range 3..9.
- CW, 8: coefficient width in bits, unsigned.
- NKERN, 4: number of stored kernels. Must be a power of two, 2..16.
- Derived, not overridable: RW = $clog2(KSIZE), SW = $clog2(NKERN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to stream the kernel given by sel. Sampled only in IDLE.
- sel  in  SW  kernel index. Latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until the cycle after the last row handshake.
- row_valid  out  1  row_data/row_idx/row_last are valid.
- row_ready  in  1  consumer accepts the current row.
- row_idx  out  RW  row number currently presented.
- row_last  out  1  high with row_idx == KSIZE-1.
- row_data  out  KSIZE*CW  packed row. Column 0 sits in the MSBs [KSIZE*CW-1 -: CW].
- wr_en  in  1  coefficient row write (present only with KERN_WR_EN).
- wr_kern  in  SW  target kernel (present only with KERN_WR_EN).
- wr_row  in  RW  target row (present only with KERN_WR_EN).
- wr_data  in  KSIZE*CW  new row contents, same packing as row_data (present only with KERN_WR_EN).

Behaviour:
- Reset: asynchronous on rst_n low. FSM goes to IDLE. busy, row_valid, row_last = 0; row_idx = 0; row_data = 0. Coefficient storage is NOT touched by reset.
- Storage: NKERN*KSIZE rows of KSIZE*CW bits, initialised at configuration.
  - For KSIZE=5, CW=8:
    - kernel 0 = Gaussian rows 0x0103040301, 0x030c130c03, 0x0413201304, 0x030c130c03, 0x0103040301.
    - kernel 1 = identity (centre coefficient 0x01, all others 0).
    - kernel 2 = box (all 0x01).
    - kernel 3 = all zero.
  - For any other KSIZE/CW, every kernel initialises to identity. Kernels at index >= 4 also initialise to identity.
- FSM states: IDLE, STREAM.
  - IDLE, start=1: latch sel, load row_data <= mem[sel][0], row_idx <= 0, row_valid <= 1, busy <= 1, go to STREAM. First row is valid 1 cycle after start.
  - STREAM, row_valid & !row_ready: hold all outputs stable.
  - STREAM, row_valid & row_ready & !row_last: row_idx+1, row_data <= next row in the same cycle. Back-to-back throughput is 1 row/cycle.
  - STREAM, row_valid & row_ready & row_last: row_valid <= 0, busy <= 0, row_idx <= 0, return to IDLE. row_data holds its last value.
  - start while in STREAM is ignored. A start in the cycle busy falls is also ignored; it is accepted the following cycle if still high.
- row_last is combinational on row_idx == KSIZE-1, gated by row_valid.
- The latched kernel index does not change mid-stream even if sel changes.
- Reset asserted mid-stream aborts immediately: row_valid drops asynchronously and no further rows are presented.

Optional Feature:
- Macro: KERN_WR_EN.
- Defined:
  - wr_* ports exist. A write takes effect at the clk edge where wr_en=1.
  - A write to a row not yet presented in the current stream is visible when that row is fetched.
  - A write to the row currently presented does not alter row_data until it is next fetched.
  - A write that coincides with the fetch of the same row is read-before-write: the old value is presented.
  - wr_en is ignored while rst_n = 0.
- Undefined: wr_* ports are absent, storage is read-only with initial contents only, and no write logic is synthesised.

Test Plan:
- Reset, then start=1 sel=0 for 1 cycle, row_ready=1 held -> rows 0..4 on 5 consecutive cycles starting 1 cycle after start; row 2 = 0x0413201304; row_last only with row_idx=4; busy low 6 cycles after start.
- sel=1, row_ready toggling 1/0 -> each row held while ready=0; row 2 = 0x0000010000; others 0.
- Start accepted, then sel changed to 2 and start pulsed again mid-stream -> second start ignored, all 5 rows from kernel 1, no restart.
- rst_n low while row_idx=2 -> row_valid=0, busy=0, row_idx=0 immediately; a new start after release streams kernel 0 from row 0.
- (KERN_WR_EN) write kern 0 row 3 = 0xAABBCCDDEE while row 1 presented and stalled -> row 1 unchanged, row 3 reads 0xAABBCCDDEE; after reset, row 3 is still 0xAABBCCDDEE.
- (KERN_WR_EN) write kern 2 row 0 in the same cycle start sel=2 is accepted -> row 0 presents 0x0101010101; a second stream of kernel 2 presents the new value.

Source files
------------

// File: rtl/kernel_coef_bank.sv
// kernel_coef_bank
//   Multi-kernel coefficient store for the video convolution path. It holds
//   NKERN kernels of KSIZE x KSIZE unsigned CW-bit coefficients. A start
//   request streams the selected kernel one row per beat over valid/ready.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   start, sel           stream request and kernel index (sampled in IDLE)
//   busy                 high while a kernel stream is in flight
//   row_valid/row_ready  row handshake
//   row_idx, row_last    current row number, high on the final row
//   row_data             packed row, column 0 in the MSBs
//   wr_en, wr_kern,      runtime row reload; present only when the
//   wr_row, wr_data      KERN_WR_EN macro is defined
//
// Optional feature macro: KERN_WR_EN (undefined = read-only initial contents)
module kernel_coef_bank #(
   parameter int KSIZE = 5,
   parameter int CW    = 8,
   parameter int NKERN = 4,
   localparam int RW   = $clog2(KSIZE),
   localparam int SW   = $clog2(NKERN)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SW-1:0]       sel,
   output logic                busy,
   output logic                row_valid,
   input  logic                row_ready,
   output logic [RW-1:0]       row_idx,
   output logic                row_last,
`ifdef KERN_WR_EN
   input  logic                wr_en,
   input  logic [SW-1:0]       wr_kern,
   input  logic [RW-1:0]       wr_row,
   input  logic [KSIZE*CW-1:0] wr_data,
`endif
   output logic [KSIZE*CW-1:0] row_data
);

   localparam int RDW   = KSIZE*CW;
   localparam int NROWS = NKERN*KSIZE;
   localparam int AW    = $clog2(NROWS);

   typedef enum logic {IDLE, STREAM} state_t;

   // Configuration-time contents. The 5x5/8-bit build carries the filter
   // set; any other geometry (and kernels 4 and up) defaults to identity.
   function automatic logic [RDW-1:0] init_row(input int k, input int r);
      logic [RDW-1:0] v;
      v = '0;
      if (KSIZE == 5 && CW == 8 && k < 4) begin
         case (k)
            0: begin
               case (r)
                  0, 4:    v = RDW'(40'h0103040301);
                  1, 3:    v = RDW'(40'h030c130c03);
                  default: v = RDW'(40'h0413201304);
               endcase
            end
            1:       if (r == 2) v = RDW'(40'h0000010000);
            2:       v = RDW'(40'h0101010101);
            default: v = '0;
         endcase
      end else if (r == KSIZE/2) begin
         v[(KSIZE-1-KSIZE/2)*CW] = 1'b1;
      end
      return v;
   endfunction

   logic [NROWS-1:0][RDW-1:0] rows;

`ifdef KERN_WR_EN
   logic [AW-1:0] wr_addr;
   logic          wr_ok;

   // Rows beyond KSIZE-1 would alias into the next kernel, so drop them.
   assign wr_addr = AW'(wr_kern)*AW'(KSIZE) + AW'(wr_row);
   assign wr_ok   = rst_n && wr_en && (int'(wr_row) < KSIZE);
`endif

   for (genvar i = 0; i < NROWS; i++) begin : g_row
`ifdef KERN_WR_EN
      // Storage carries a power-up value and is deliberately outside reset.
      logic [RDW-1:0] coef_q = init_row(i/KSIZE, i%KSIZE);
      logic [RDW-1:0] coef_d;

      always_comb begin
         coef_d = coef_q;
         if (wr_ok && wr_addr == AW'(i)) coef_d = wr_data;
      end

      always_ff @(posedge clk) coef_q <= coef_d;

      assign rows[i] = coef_q;
`else
      assign rows[i] = init_row(i/KSIZE, i%KSIZE);
`endif
   end

   state_t          state_q, state_d;
   logic [SW-1:0]   kern_q, kern_d;
   logic [RW-1:0]   row_idx_q, row_idx_d;
   logic [RDW-1:0]  row_data_q, row_data_d;
   logic            row_valid_q, row_valid_d;
   logic            busy_q, busy_d;
   logic [AW-1:0]   rd_addr;

   assign row_last = row_valid_q && (row_idx_q == RW'(KSIZE-1));

   // Fetches read the storage before any same-edge write lands, so a
   // coinciding write is seen only on the next fetch of that row.
   always_comb begin
      state_d     = state_q;
      kern_d      = kern_q;
      row_idx_d   = row_idx_q;
      row_data_d  = row_data_q;
      row_valid_d = row_valid_q;
      busy_d      = busy_q;
      rd_addr     = AW'(kern_q)*AW'(KSIZE) + AW'(row_idx_q) + AW'(1);
      case (state_q)
         IDLE: begin
            if (start) begin
               kern_d      = sel;
               rd_addr     = AW'(sel)*AW'(KSIZE);
               row_data_d  = rows[rd_addr];
               row_idx_d   = '0;
               row_valid_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = STREAM;
            end
         end
         default: begin
            if (row_valid_q && row_ready) begin
               if (row_last) begin
                  // row_data keeps the final row after the stream ends
                  row_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  row_idx_d   = '0;
                  state_d     = IDLE;
               end else begin
                  row_idx_d  = row_idx_q + RW'(1);
                  row_data_d = rows[rd_addr];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         kern_q      <= '0;
         row_idx_q   <= '0;
         row_data_q  <= '0;
         row_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         kern_q      <= kern_d;
         row_idx_q   <= row_idx_d;
         row_data_q  <= row_data_d;
         row_valid_q <= row_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign row_valid = row_valid_q;
   assign row_idx   = row_idx_q;
   assign row_data  = row_data_q;

endmodule
